conv_im2col_window: RTL and testbench

- Upstream feeder for the convolution accelerator.
- Accepts a raster-order 8-bit image stream, IMG_H x IMG_W (default 28x28).
- Uses two line buffers and a 3x3 register window to emit one flattened 3x3 patch per valid output position, (IMG_H-2) x (IMG_W-2) = 26x26 patches per frame.
- Valid/ready handshake on both sides; the accelerator consumes patches in the same row-major order as its result array.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_line_buffer.sv | 25 ++
 rtl/conv_im2col_window.sv | 140 ++++++++++++++
 tb/tb_conv_im2col_window.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, index-width helper and window type for the im2col window feeder.
package conv_pkg;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int DW_DEF    = 8;
    localparam int KSZ       = 3;
    localparam int NTAP      = KSZ * KSZ;
    localparam int OUT_W     = IMG_W_DEF - 2;
    localparam int OUT_H     = IMG_H_DEF - 2;

    typedef logic [DW_DEF-1:0] window_t [NTAP];

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = idx_w(IMG_W_DEF);
    localparam int ROW_W = idx_w(IMG_H_DEF);
endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage; the combinational read returns the old word on the
// address being written this cycle, so the caller sees read-before-write order.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/conv_im2col_window.sv
// Raster pixel stream to flattened 3x3 patches via two line buffers and a 3x3 window.
// Optional macro IM2COL_SOF_EN adds pix_sof framing and the sof_err pulse.
module conv_im2col_window
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF,
    localparam int CW   = idx_w(IMG_W),
    localparam int RW   = idx_w(IMG_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [DW-1:0]      pix_data,
`ifdef IM2COL_SOF_EN
    input  logic               pix_sof,
    output logic               sof_err,
`endif
    output logic               win_valid,
    input  logic               win_ready,
    output logic [NTAP*DW-1:0] win_data,
    output logic [RW-1:0]      win_row,
    output logic [CW-1:0]      win_col,
    output logic               win_last
);
    logic          accept;
    logic          emit;
    logic          row_end;
    logic          frame_end;
    logic [RW-1:0] r_q;
    logic [RW-1:0] r_cur;
    logic [CW-1:0] c_q;
    logic [CW-1:0] c_cur;
    logic [DW-1:0] lb_a_rd;
    logic [DW-1:0] lb_b_rd;
    logic [DW-1:0] col_in [KSZ];
    logic [DW-1:0] tap_p0 [NTAP];

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;

`ifdef IM2COL_SOF_EN
    // A start-of-frame marker overrides the counters before they address anything.
    assign r_cur = pix_sof ? '0 : r_q;
    assign c_cur = pix_sof ? '0 : c_q;
`else
    assign r_cur = r_q;
    assign c_cur = c_q;
`endif

    assign row_end   = (c_cur == CW'(IMG_W - 1));
    assign frame_end = row_end && (r_cur == RW'(IMG_H - 1));
    assign emit      = accept && (r_cur >= RW'(2)) && (c_cur >= CW'(2));

    conv_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb_a (
        .clk   (clk),
        .we    (accept),
        .addr  (c_cur),
        .wdata (pix_data),
        .rdata (lb_a_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb_b (
        .clk   (clk),
        .we    (accept),
        .addr  (c_cur),
        .wdata (lb_a_rd),
        .rdata (lb_b_rd)
    );

    assign col_in[0] = lb_b_rd;
    assign col_in[1] = lb_a_rd;
    assign col_in[2] = pix_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
            c_q <= '0;
        end else if (accept) begin
            if (row_end) begin
                c_q <= '0;
                r_q <= frame_end ? '0 : r_cur + 1'b1;
            end else begin
                c_q <= c_cur + 1'b1;
                r_q <= r_cur;
            end
        end
    end

    // p0: window shifts left on every accepted pixel; the newest column enters at the right
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAP; k++) begin
                tap_p0[k] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < KSZ; i++) begin
                for (int j = 0; j < KSZ - 1; j++) begin
                    tap_p0[i*KSZ+j] <= tap_p0[i*KSZ+j+1];
                end
                tap_p0[i*KSZ+KSZ-1] <= col_in[i];
            end
        end
    end

    for (genvar k = 0; k < NTAP; k++) begin : g_flat
        assign win_data[DW*k +: DW] = tap_p0[k];
    end

    // p1: patch tag registers, held while the consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            win_last  <= 1'b0;
        end else if (accept) begin
            win_valid <= emit;
            if (emit) begin
                win_row  <= r_cur - RW'(2);
                win_col  <= c_cur - CW'(2);
                win_last <= frame_end;
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

`ifdef IM2COL_SOF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sof_err <= 1'b0;
        end else begin
            sof_err <= accept && pix_sof && ((r_q != '0) || (c_q != '0));
        end
    end
`endif
endmodule

// File: tb/tb_conv_im2col_window.sv
// Randomized/directed bench for conv_im2col_window against a frame-level patch model.
module tb_conv_im2col_window;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int DW = 8;
    localparam int NP = W * H;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    typedef logic [127:0] v_t;
    typedef struct { logic [DW-1:0] data; bit sof; } pix_t;
    typedef struct {
        logic [9*DW-1:0] data;
        logic [RW-1:0]   row;
        logic [CW-1:0]   col;
        logic            last;
    } patch_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            pix_valid = 1'b0;
    logic            pix_ready;
    logic [DW-1:0]   pix_data = '0;
    logic            win_valid;
    logic            win_ready = 1'b0;
    logic [9*DW-1:0] win_data;
    logic [RW-1:0]   win_row;
    logic [CW-1:0]   win_col;
    logic            win_last;
`ifdef IM2COL_SOF_EN
    logic            pix_sof = 1'b0;
    logic            sof_err;
`endif

    pix_t   pq [$];
    patch_t eq [$];
    int     img [H][W];
    int     total = 0;
    int     bad = 0;
    int     nret;
    int     nlast;
    int     sof_seen = 0;
    logic [9*DW-1:0] first_data;
    logic [9*DW-1:0] last_data;
    logic [9*DW-1:0] ramp_first;

    conv_im2col_window #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
`ifdef IM2COL_SOF_EN
        .pix_sof   (pix_sof),
        .sof_err   (sof_err),
`endif
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_last  (win_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input v_t got, input v_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // kind 0: ramp, 1: inverted ramp, 2: random. Only patches whose bottom-right
    // pixel lies within the first npix pixels are expected.
    task automatic push_frame(input int kind, input int npix, input bit sof_first);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int v;
                v = (W * r + c) & 255;
                if (kind == 1) v = 255 - v;
                if (kind == 2) v = int'($urandom_range(0, 255));
                img[r][c] = v;
            end
        end
        for (int i = 0; i < npix; i++) begin
            pix_t p;
            p.data = 8'(img[i / W][i % W]);
            p.sof  = sof_first && (i == 0);
            pq.push_back(p);
        end
        for (int pr = 0; pr < H - 2; pr++) begin
            for (int pc = 0; pc < W - 2; pc++) begin
                if ((pr + 2) * W + pc + 2 < npix) begin
                    patch_t e;
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++)
                            e.data[DW*(kr*3+kc) +: DW] = 8'(img[pr+kr][pc+kc]);
                    e.row  = RW'(pr);
                    e.col  = CW'(pc);
                    e.last = (pr == H - 3) && (pc == W - 3);
                    eq.push_back(e);
                end
            end
        end
    endtask

    // mode 0: full rate, 1: random valid/ready, 2: full rate with a 5-cycle stall on the first patch
    task automatic run(input int mode, input int budget);
        int cyc = 0;
        int stall_left = 0;
        bit stall_done = 0;
        logic [9*DW-1:0] held;
        logic [RW+CW-1:0] held_pos;
        nret = 0;
        nlast = 0;
        while ((pq.size() > 0 || eq.size() > 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pq.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                pix_valid = 1'b1;
                pix_data  = pq[0].data;
`ifdef IM2COL_SOF_EN
                pix_sof   = pq[0].sof;
`endif
            end else begin
                pix_valid = 1'b0;
`ifdef IM2COL_SOF_EN
                pix_sof   = 1'b0;
`endif
            end
            win_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode == 2 && !stall_done && win_valid) begin
                stall_done = 1;
                stall_left = 5;
                held       = win_data;
                held_pos   = {win_row, win_col};
            end
            if (stall_left > 0) win_ready = 1'b0;
            #1;
            if (stall_left > 0) begin
                chk("stall_pix_ready", v_t'(pix_ready), v_t'(0));
                chk("stall_data", v_t'(win_data), v_t'(held));
                chk("stall_pos", v_t'({win_row, win_col}), v_t'(held_pos));
                stall_left--;
            end
`ifdef IM2COL_SOF_EN
            if (sof_err) sof_seen++;
`endif
            if (win_valid && win_ready) begin
                chk("patch_avail", v_t'(eq.size() > 0), v_t'(1));
                if (eq.size() > 0) begin
                    chk("patch_data", v_t'(win_data), v_t'(eq[0].data));
                    chk("patch_pos", v_t'({win_row, win_col, win_last}),
                        v_t'({eq[0].row, eq[0].col, eq[0].last}));
                    void'(eq.pop_front());
                end
                if (nret == 0) first_data = win_data;
                if (win_last) begin
                    nlast++;
                    last_data = win_data;
                end
                nret++;
            end
            if (pix_valid && pix_ready) void'(pq.pop_front());
        end
        @(negedge clk);
        pix_valid = 1'b0;
        win_ready = 1'b1;
`ifdef IM2COL_SOF_EN
        pix_sof = 1'b0;
`endif
        chk("run_drain", v_t'(pq.size() + eq.size()), v_t'(0));
        pq.delete();
        eq.delete();
    endtask

    initial begin
        ramp_first = {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};

        // reset held with pixels offered
        reset = 1'b0;
        pix_valid = 1'b1;
        pix_data = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_win_valid", v_t'(win_valid), v_t'(0));
        chk("rst_win_data", v_t'(win_data), v_t'(0));
        chk("rst_pix_ready", v_t'(pix_ready), v_t'(1));
        chk("rst_pos", v_t'({win_row, win_col, win_last}), v_t'(0));
        pix_valid = 1'b0;
        reset = 1'b1;

        // ramp frame at full rate
        push_frame(0, NP, 0);
        run(0, 4 * NP);
        chk("ramp_count", v_t'(nret), v_t'(676));
        chk("ramp_first", v_t'(first_data), v_t'(ramp_first));
        chk("ramp_last_k8", v_t'(last_data[8*DW +: DW]), v_t'(15));
        chk("ramp_nlast", v_t'(nlast), v_t'(1));

        // stall at first patch, then an inverted-ramp frame back-to-back
        push_frame(0, NP, 0);
        push_frame(1, NP, 0);
        run(2, 8 * NP);
        chk("b2b_count", v_t'(nret), v_t'(1352));
        chk("b2b_first", v_t'(first_data), v_t'(ramp_first));
        chk("b2b_nlast", v_t'(nlast), v_t'(2));

        // 100 pixels, one more pending patch, then reset mid-frame
        push_frame(0, 100, 0);
        run(0, 1000);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data = 8'h11;
        win_ready = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        chk("mid_pending", v_t'(win_valid), v_t'(1));
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", v_t'(win_valid), v_t'(0));
        chk("mid_rst_data", v_t'(win_data), v_t'(0));
        chk("mid_rst_pos", v_t'({win_row, win_col, win_last}), v_t'(0));
        @(negedge clk);
        reset = 1'b1;
        win_ready = 1'b1;

        push_frame(0, NP, 0);
        run(1, 10 * NP);
        chk("post_rst_count", v_t'(nret), v_t'(676));
        chk("post_rst_first", v_t'(first_data), v_t'(ramp_first));

        // random frames with random handshakes
        push_frame(2, NP, 0);
        push_frame(2, NP, 0);
        run(1, 20 * NP);
        chk("rand_count", v_t'(nret), v_t'(1352));
        chk("rand_nlast", v_t'(nlast), v_t'(2));

`ifdef IM2COL_SOF_EN
        chk("sof_quiet", v_t'(sof_seen), v_t'(0));
        sof_seen = 0;
        push_frame(2, 50, 0);
        push_frame(0, NP, 1);
        run(0, 4 * NP);
        chk("sof_err_once", v_t'(sof_seen), v_t'(1));
        chk("sof_count", v_t'(nret), v_t'(676));
        chk("sof_first", v_t'(first_data), v_t'(ramp_first));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
